// File: rtl/mul_div_if.sv
// mul_div_if: start/busy/done handshake, operands and HI/LO result between control and mul_div_unit.
interface mul_div_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divzero;
    modport master (output start, op, a, b, input busy, done, hi, lo, divzero);
    modport slave  (input start, op, a, b, output busy, done, hi, lo, divzero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply and restoring divide, one bit per clock,
// producing a MIPS-style HI/LO pair. Sign handling is done on magnitudes plus a FIX step.
module mul_div_unit #(parameter int WIDTH = 32) (
    input logic      clk,
    input logic      rst,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d, araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic               busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;
    logic               a_neg, b_neg, ge;
    logic [WIDTH-1:0]   a_abs, b_abs, rem_new;
    logic [WIDTH:0]     msum, rem_sh;
    always_comb begin
        a_neg     = bus.op[0] & bus.a[WIDTH-1];
        b_neg     = bus.op[0] & bus.b[WIDTH-1];
        a_abs     = a_neg ? -bus.a : bus.a;
        b_abs     = b_neg ? -bus.b : bus.b;
        // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
        msum      = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        rem_sh    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        ge        = rem_sh >= {1'b0, m_q};
        rem_new   = ge ? WIDTH'(rem_sh - {1'b0, m_q}) : rem_sh[WIDTH-1:0];
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        m_d       = m_q;
        araw_d    = araw_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;
        busy_d    = state_q == RUN || state_q == FIX;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                cnt_d   = '0;
                p_d     = {{WIDTH{1'b0}}, a_abs};
                m_d     = b_abs;
                araw_d  = bus.a;
                div_d   = bus.op[1];
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dz_d    = bus.op[1] && bus.b == '0;
            end
            RUN: begin
                p_d     = div_q ? {rem_new, p_q[WIDTH-2:0], ge} : {msum, p_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH - 1) ? FIX : RUN;
            end
            FIX: begin
                // signed overflow (MIN / -1) falls out naturally: |MIN| negated wraps back to MIN
                p_d     = dz_q  ? {araw_q, {WIDTH{1'b1}}} :
                          div_q ? {rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH],
                                   neg_q  ? -p_q[WIDTH-1:0]       : p_q[WIDTH-1:0]} :
                          neg_q ? -p_q : p_q;
                state_d = DONE;
            end
            DONE: begin
                done_d    = 1'b1;
                hi_d      = p_q[2*WIDTH-1:WIDTH];
                lo_d      = p_q[WIDTH-1:0];
                divzero_d = dz_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            m_q       <= '0;
            araw_q    <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            m_q       <= m_d;
            araw_q    <= araw_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.divzero = divzero_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus hand-written sequences for
// mid-run start, operand changes, back-to-back start and reset abort.
module tb_mul_div_unit;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [12];
    mul_div_if #(.WIDTH(32)) bus ();
    mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    // Start an op, count sampled cycles to done and busy cycles; optionally
    // pulse a conflicting start and scramble operands while the op runs.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inj, output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) bcnt++;
            bus.start = inj && (i == 10 || i == 33);
            if (inj && i == 10) begin
                bus.op = 2'b00;
                bus.a = 32'h1234_5678;
                bus.b = 32'h0000_0003;
            end
            if (inj && i > 10) bus.a = ~bus.a;
            if (bus.done) begin
                bus.start = 1'b0;
                lat = i;
                break;
            end
        end
    endtask
    initial begin
        int lat, bcnt, dcnt;
        vecs[0]  = '{2'b00, 32'd100,        32'd752,        32'h0,          32'd75200,      1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFF9,  32'd45000,      32'hFFFF_FFFF,  32'hFFFB_3188,  1'b0};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0};
        vecs[3]  = '{2'b10, 32'd1080,       32'd25,         32'd5,          32'd43,         1'b0};
        vecs[4]  = '{2'b11, 32'hFFFF_FBC8,  32'd25,         32'hFFFF_FFFB,  32'hFFFF_FFD5,  1'b0};
        vecs[5]  = '{2'b10, 32'd333,        32'd0,          32'd333,        32'hFFFF_FFFF,  1'b1};
        vecs[6]  = '{2'b00, 32'd2,          32'd3,          32'd0,          32'd6,          1'b0};
        vecs[7]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0};
        vecs[8]  = '{2'b11, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  32'hFFFF_FFFF,  1'b1};
        vecs[9]  = '{2'b11, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  1'b0};
        vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          32'h1,          1'b0};
        vecs[11] = '{2'b10, 32'd5,          32'd7,          32'd5,          32'd0,          1'b0};
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset_dz", 64'(bus.divzero), 64'd0);
        rst = 1'b0;
        // Consecutive calls start on the cycle right after done, so back-to-back acceptance is covered too.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'd34);
            chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'd33);
            chk($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
            chk($sformatf("v%0d_dz", i), 64'(bus.divzero), 64'(vecs[i].dz));
        end
        @(posedge clk);
        #1;
        chk("done_pulse_len", 64'(bus.done), 64'd0);
        chk("hold_lo", 64'(bus.lo), 64'd0);
        chk("hold_hi", 64'(bus.hi), 64'd5);
        run_op(2'b10, 32'd1080, 32'd25, 1'b1, lat, bcnt);
        chk("inj_lat", 64'(lat), 64'd34);
        chk("inj_hi", 64'(bus.hi), 64'd5);
        chk("inj_lo", 64'(bus.lo), 64'd43);
        @(posedge clk);
        #1;
        chk("inj_no_queue", 64'(bus.busy), 64'd0);
        run_op(2'b00, 32'd9, 32'd9, 1'b0, lat, bcnt);
        chk("after_inj_lo", 64'(bus.lo), 64'd81);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.a = 32'd1000;
        bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dcnt++;
        end
        chk("rst_no_done", 64'(dcnt), 64'd0);
        run_op(2'b10, 32'd1000, 32'd7, 1'b0, lat, bcnt);
        chk("post_rst_lat", 64'(lat), 64'd34);
        chk("post_rst_hilo", {bus.hi, bus.lo}, {32'd6, 32'd142});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
